// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer
//   Write-side staging FIFO in front of the 32x32 register file. Requests are
//   accepted over a valid/ready handshake and drained one per cycle into a
//   registered WriteRegister/WriteData/RegWrite stage. Writes to register 0
//   are accepted but dropped.
//
//   Optional feature macro: WRBUF_BYPASS_EN
//     defined   -> two combinational lookup ports return the newest pending
//                  value (queue entries, then the output stage).
//     undefined -> LookupHit1/2 and LookupData1/2 are tied to 0.
//
// Ports:
//   Clk, Reset_n                     clock / async active-low reset
//   InValid, InReady                 request handshake
//   InRegister, InData               request payload
//   DrainEn                          allow a pop toward the regfile
//   WriteRegister, WriteData, RegWrite  registered regfile write port
//   LookupRegister1/2                bypass lookup addresses
//   LookupData1/2, LookupHit1/2      bypass results
//   Count, Empty, Full               queue occupancy (output stage excluded)
module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [AW-1:0]            InRegister,
  input  logic [DW-1:0]            InData,
  input  logic                     DrainEn,
  output logic [AW-1:0]            WriteRegister,
  output logic [DW-1:0]            WriteData,
  output logic                     RegWrite,
  input  logic [AW-1:0]            LookupRegister1,
  input  logic [AW-1:0]            LookupRegister2,
  output logic [DW-1:0]            LookupData1,
  output logic [DW-1:0]            LookupData2,
  output logic                     LookupHit1,
  output logic                     LookupHit2,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty,
  output logic                     Full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] mem_reg;
  logic [DEPTH-1:0][DW-1:0] mem_data;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic                     accept, push, pop;

  assign Full    = (Count == CW'(DEPTH));
  assign Empty   = (Count == '0);
  // Gated by reset so upstream never sees a handshake while the buffer is held.
  assign InReady = Reset_n && !Full;
  assign accept  = InValid && InReady;
  // Register 0 writes complete the handshake but never enter the queue.
  assign push    = accept && (InRegister != '0);
  // Count is the pre-edge value, so a just-accepted entry cannot fall through.
  assign pop     = DrainEn && (Count != '0);

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_reg[wr_ptr]  <= InRegister;
      mem_data[wr_ptr] <= InData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      Count         <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        WriteRegister <= mem_reg[rd_ptr];
        WriteData     <= mem_data[rd_ptr];
      end
      RegWrite <= pop;
      Count    <= Count + CW'(push) - CW'(pop);
    end
  end

`ifdef WRBUF_BYPASS_EN
  logic [1:0][AW-1:0] lk_reg;
  logic [1:0][DW-1:0] lk_data;
  logic [1:0]         lk_hit;
  logic [PW-1:0]      idx;

  assign lk_reg = {LookupRegister2, LookupRegister1};

  // Scan oldest-to-youngest so later matches overwrite earlier ones; the
  // output stage is checked first, giving it the lowest priority.
  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    idx     = '0;
    for (int p = 0; p < 2; p++) begin
      if (lk_reg[p] != '0) begin
        if (RegWrite && (WriteRegister == lk_reg[p])) begin
          lk_hit[p]  = 1'b1;
          lk_data[p] = WriteData;
        end
        for (int i = 0; i < DEPTH; i++) begin
          idx = rd_ptr + PW'(i);
          if ((CW'(i) < Count) && (mem_reg[idx] == lk_reg[p])) begin
            lk_hit[p]  = 1'b1;
            lk_data[p] = mem_data[idx];
          end
        end
      end
    end
  end

  assign LookupHit1  = lk_hit[0];
  assign LookupHit2  = lk_hit[1];
  assign LookupData1 = lk_data[0];
  assign LookupData2 = lk_data[1];
`else
  logic unused_lookup;
  assign unused_lookup = ^{LookupRegister1, LookupRegister2};
  assign LookupHit1    = 1'b0;
  assign LookupHit2    = 1'b0;
  assign LookupData1   = '0;
  assign LookupData2   = '0;
`endif

endmodule
